// File: rtl/pri_arbiter.sv
// N-way sequential arbiter with a registered one-hot grant, grant hold, a hold-time limit and one turnaround cycle between owners.
// Optional rotating priority: define ROUND_ROBIN_EN (default build is fixed priority, highest index wins).
module pri_arbiter #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           timeout
);

    // state   | meaning
    // IDLE    | no owner, arbitrate every cycle
    // GRANT   | owner gnt_id_q holds the resource
    // RELEASE | one turnaround cycle with gnt = 0, arbitrate for the next owner
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic           gnt_valid_q, gnt_valid_d;
    logic           timeout_q, timeout_d;
    logic [7:0]     hold_cnt_q, hold_cnt_d;
    logic [N-1:0]   mask_q, mask_d;

    logic [N-1:0]   masked_req;
    logic           win_found;
    logic [IDW-1:0] win_id;

`ifdef ROUND_ROBIN_EN
    logic [IDW-1:0] last_id_q, last_id_d;
    logic [IDW-1:0] idx_v;

    // Scan from farthest to nearest so the nearest index below last_id wins.
    always_comb begin
        masked_req = req & ~mask_q;
        win_found  = 1'b0;
        win_id     = '0;
        idx_v      = '0;
        for (int i = N; i >= 1; i--) begin
            idx_v = IDW'((int'(last_id_q) + N - i) % N);
            if (masked_req[idx_v]) begin
                win_found = 1'b1;
                win_id    = idx_v;
            end
        end
    end
`else
    always_comb begin
        masked_req = req & ~mask_q;
        win_found  = 1'b0;
        win_id     = '0;
        for (int i = 0; i < N; i++) begin
            if (masked_req[IDW'(i)]) begin
                win_found = 1'b1;
                win_id    = IDW'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        mask_d      = mask_q;
`ifdef ROUND_ROBIN_EN
        last_id_d   = last_id_q;
`endif
        case (state_q)
            IDLE, RELEASE: begin
                mask_d      = '0;
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
                state_d     = IDLE;
                if (win_found) begin
                    state_d     = GRANT;
                    gnt_d       = N'(1) << win_id;
                    gnt_id_d    = win_id;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = 8'd1;
`ifdef ROUND_ROBIN_EN
                    last_id_d   = win_id;
`endif
                end
            end
            GRANT: begin
                if (!req[gnt_id_q] || hold_cnt_q == 8'(MAX_HOLD)) begin
                    state_d     = RELEASE;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    // A voluntary release on the limit cycle wins over the timeout.
                    if (req[gnt_id_q]) begin
                        timeout_d = 1'b1;
                        mask_d    = gnt_q;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
                mask_d      = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
            mask_q      <= '0;
`ifdef ROUND_ROBIN_EN
            last_id_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
            mask_q      <= mask_d;
`ifdef ROUND_ROBIN_EN
            last_id_q   <= last_id_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_pri_arbiter.sv
// Directed bench for pri_arbiter: one instance with MAX_HOLD = 15, one with MAX_HOLD = 4.
module tb_pri_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] req4 = '0;
    logic [3:0] gnt, gnt4;
    logic [1:0] gnt_id, gnt_id4;
    logic       gnt_valid, gnt_valid4;
    logic       timeout, timeout4;
    logic       prev_valid = 1'b0;
    logic       prev_valid4 = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    pri_arbiter #(.N(4), .IDW(2), .MAX_HOLD(15)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_id(gnt_id),
        .gnt_valid(gnt_valid), .timeout(timeout)
    );

    pri_arbiter #(.N(4), .IDW(2), .MAX_HOLD(4)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .gnt(gnt4), .gnt_id(gnt_id4),
        .gnt_valid(gnt_valid4), .timeout(timeout4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Structural properties, checked every cycle on both instances.
    always @(negedge clk) begin
        chk("onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("valid_or", 32'(gnt_valid), 32'(|gnt));
        if (!gnt_valid) chk("id_zero", 32'(gnt_id), 32'd0);
        if (timeout) chk("to_after_gnt", 32'(prev_valid), 32'd1);
        chk("onehot0_4", 32'($onehot0(gnt4)), 32'd1);
        chk("valid_or_4", 32'(gnt_valid4), 32'(|gnt4));
        if (timeout4) chk("to_after_gnt_4", 32'(prev_valid4), 32'd1);
        prev_valid  = gnt_valid;
        prev_valid4 = gnt_valid4;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with all requests high.
        rst = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_valid", 32'(gnt_valid), 32'd0);
            chk("rst_to", 32'(timeout), 32'd0);
        end
        rst = 1'b0;
        step();
        chk("first_gnt", 32'(gnt), 32'b1000);
        chk("first_id", 32'(gnt_id), 32'd3);
        req = 4'b0000;
        step();
        chk("first_rel", 32'(gnt), 32'd0);
        step();

        // Latency and fixed priority.
        req = 4'b0110;
        step();
        chk("lat_gnt", 32'(gnt), 32'b0100);
        chk("lat_id", 32'(gnt_id), 32'd2);
        req = 4'b0010;
        step();
        chk("turn_gnt", 32'(gnt), 32'd0);
        chk("turn_valid", 32'(gnt_valid), 32'd0);
        step();
        chk("next_gnt", 32'(gnt), 32'b0010);
        chk("next_id", 32'(gnt_id), 32'd1);
        req = 4'b0000;
        step();
        step();

        // Hold limit, MAX_HOLD = 15, single requester.
        req = 4'b0001;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("hold_gnt", 32'(gnt), 32'b0001);
            chk("hold_to", 32'(timeout), 32'd0);
        end
        step();
        chk("lim_gnt", 32'(gnt), 32'd0);
        chk("lim_to", 32'(timeout), 32'd1);
        step();
        chk("gap_gnt", 32'(gnt), 32'd0);
        chk("gap_to", 32'(timeout), 32'd0);
        step();
        chk("regrant", 32'(gnt), 32'b0001);

        // Release on the limit cycle: no timeout.
        for (int i = 0; i < 14; i++) step();
        chk("pre_lim_gnt", 32'(gnt), 32'b0001);
        req = 4'b0000;
        step();
        chk("sim_gnt", 32'(gnt), 32'd0);
        chk("sim_to", 32'(timeout), 32'd0);
        step();
        chk("sim_idle_to", 32'(timeout), 32'd0);
        step();

        // Timeout fairness, MAX_HOLD = 4, req = 1001.
        req4 = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fair_g3", 32'(gnt4), 32'b1000);
        end
        step();
        chk("fair_to1_gnt", 32'(gnt4), 32'd0);
        chk("fair_to1", 32'(timeout4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fair_g0", 32'(gnt4), 32'b0001);
            chk("fair_id0", 32'(gnt_id4), 32'd0);
        end
        step();
        chk("fair_to2", 32'(timeout4), 32'd1);
        step();
        chk("fair_g3b", 32'(gnt4), 32'b1000);
        chk("fair_id3", 32'(gnt_id4), 32'd3);
        req4 = 4'b0000;
        step();
        step();

        // Reset in the middle of a grant (hold_cnt = 7).
        req = 4'b0100;
        for (int i = 0; i < 7; i++) step();
        chk("mid_gnt", 32'(gnt), 32'b0100);
        rst = 1'b1;
        step();
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_to", 32'(timeout), 32'd0);
        rst = 1'b0;
        req = 4'b1100;
        step();
        chk("post_rst_gnt", 32'(gnt), 32'b1000);
        req = 4'b0000;
        step();
        step();

`ifdef ROUND_ROBIN_EN
        // Rotating priority: grant order 3, 2, 1, 0, 3.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        step();
        begin
            logic [3:0] rr_exp [5];
            rr_exp = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
            for (int k = 0; k < 5; k++) begin
                chk("rr_gnt", 32'(gnt), 32'(rr_exp[k]));
                step();
                chk("rr_hold", 32'(gnt), 32'(rr_exp[k]));
                req = 4'b1111 & ~rr_exp[k];
                step();
                chk("rr_rel", 32'(gnt), 32'd0);
                req = 4'b1111;
                step();
            end
        end
        req = 4'b0000;
        step();
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
